// File: rtl/sram_fsm.sv
// Single-port synchronous SRAM with active-low enables and a registered read port.
// A three-state controller decodes the enables at every rising edge.
module sram_fsm #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_SIZE   = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_enable_n,
    input  logic                  write_enable_n,
    input  logic                  read_enable_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t current_state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];
    logic                  addr_valid;

    assign addr_valid = (32'(address) < MEM_SIZE);

    // Conflicting or deselected requests fall through to IDLE.
    always_comb begin
        next_state = IDLE;
        if (!chip_enable_n && !write_enable_n && read_enable_n) begin
            next_state = WRITE;
        end else if (!chip_enable_n && write_enable_n && !read_enable_n) begin
            next_state = READ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= IDLE;
            data_out      <= '0;
            for (int i = 0; i < int'(MEM_SIZE); i++) begin
                mem[i[ADDR_WIDTH-1:0]] <= '0;
            end
        end else begin
            current_state <= next_state;
            if (next_state == WRITE && addr_valid) begin
                mem[address] <= data_in;
            end
            // Read data is held only for the cycle after a valid read edge.
            if (next_state == READ && addr_valid) begin
                data_out <= mem[address];
            end else begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_fsm.sv
// Scoreboard bench for sram_fsm: driver pushes expected responses, monitor pops and compares.
module tb_sram_fsm;

    localparam int ST_IDLE  = 0;
    localparam int ST_READ  = 1;
    localparam int ST_WRITE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chip_enable_n = 1'b1;
    logic       write_enable_n = 1'b1;
    logic       read_enable_n = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    typedef struct {
        logic [7:0] data;
        int         st;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [0:255];
    int         total = 0;
    int         passed = 0;

    sram_fsm #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .MEM_SIZE  (256)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .chip_enable_n (chip_enable_n),
        .write_enable_n(write_enable_n),
        .read_enable_n (read_enable_n),
        .address       (address),
        .data_in       (data_in),
        .data_out      (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Model: what the edge after this request should produce, from the access rules alone.
    task automatic step(input logic rst, input logic ce_n, input logic we_n, input logic re_n,
                        input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        reset = rst;
        chip_enable_n = ce_n;
        write_enable_n = we_n;
        read_enable_n = re_n;
        address = a;
        data_in = d;
        e.data = 8'h00;
        e.st = ST_IDLE;
        if (rst) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        end else if (!ce_n && !we_n && re_n) begin
            e.st = ST_WRITE;
            ref_mem[a] = d;
        end else if (!ce_n && we_n && !re_n) begin
            e.st = ST_READ;
            e.data = ref_mem[a];
        end
        exp_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_out", int'(data_out), int'(e.data));
            check("state", int'(dut.current_state), e.st);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       r, c, w, rd;
        logic [7:0] a;

        // Reset for two edges, then one idle edge.
        step(1, 1, 1, 1, 8'h00, 8'h00);
        step(1, 1, 1, 1, 8'h00, 8'h00);
        step(0, 1, 1, 1, 8'h00, 8'h00);
        after_edge();
        check("reset mem[0x10]", int'(dut.mem[8'h10]), 0);

        // Boundary addresses.
        step(0, 0, 0, 1, 8'h00, 8'hAA);
        step(0, 0, 0, 1, 8'h00, 8'hAA);
        step(0, 0, 0, 1, 8'hFF, 8'hFF);
        step(0, 0, 0, 1, 8'hFF, 8'hFF);
        after_edge();
        check("mem[0x00]", int'(dut.mem[8'h00]), 'hAA);
        check("mem[0xFF]", int'(dut.mem[8'hFF]), 'hFF);
        step(0, 0, 1, 0, 8'h00, 8'h00);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        step(0, 1, 1, 1, 8'h00, 8'h00);

        // Chip disabled.
        step(0, 1, 0, 1, 8'h10, 8'hBB);
        after_edge();
        check("ce_n=1 mem[0x10]", int'(dut.mem[8'h10]), 0);
        step(0, 1, 1, 0, 8'h10, 8'h00);

        // Conflicting enables.
        step(0, 0, 0, 0, 8'h20, 8'hCC);
        step(0, 0, 0, 0, 8'h20, 8'hCC);
        after_edge();
        check("conflict mem[0x20]", int'(dut.mem[8'h20]), 0);

        // Write then immediate read.
        step(0, 0, 0, 1, 8'h30, 8'hEE);
        step(0, 0, 1, 0, 8'h30, 8'h00);

        // Reset mid-write.
        step(0, 0, 0, 1, 8'h40, 8'h11);
        step(1, 0, 0, 1, 8'h40, 8'h22);
        step(0, 1, 1, 1, 8'h00, 8'h00);
        after_edge();
        check("reset mem[0x40]", int'(dut.mem[8'h40]), 0);
        check("reset mem[0x00]", int'(dut.mem[8'h00]), 0);

        // Randomised traffic, addresses mostly in a small window so reads hit written data.
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            c  = ($urandom_range(0, 5) == 0);
            w  = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 1) == 1;
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            step(r, c, w, rd, a, 8'($urandom));
        end
        step(0, 1, 1, 1, 8'h00, 8'h00);
        after_edge();
        after_edge();
        check("scoreboard drained", exp_q.size(), 0);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("final mem[%0d]", i), int'(dut.mem[i]), int'(ref_mem[i]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
